// File: rtl/sdram_write_arbiter.sv
// sdram_write_arbiter: N-channel write arbiter feeding one registered SDRAM write port,
// with round-robin / fixed-priority selection and bounded burst ownership.
`default_nettype none

module sdram_write_arbiter #(
  parameter int N_CH      = 2,
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 19,
  parameter int MAX_BURST = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic                     i_mode,
  input  logic [N_CH-1:0]          i_valid,
  input  logic [N_CH*DATA_W-1:0]   i_data,
  input  logic [N_CH*ADDR_W-1:0]   i_addr,
  output logic [N_CH-1:0]          o_ready,
  output logic [DATA_W-1:0]        o_data,
  output logic [ADDR_W-1:0]        o_addr,
  output logic                     o_enableWrite,
  input  logic                     i_sdramReady,
  output logic [N_CH-1:0]          o_grant,
  output logic                     o_busy
);

  localparam int                IDX_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int                CNT_W    = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(MAX_BURST);
  localparam logic [IDX_W-1:0]  LAST_RST = IDX_W'(N_CH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                en_q, en_d;
  logic                run_q;

  logic [IDX_W-1:0]    arb_idx;
  logic [IDX_W-1:0]    sel;
  logic                arb_found;
  logic                keep;
  logic                sel_valid;
  logic                advance;
  logic                xfer;

  // Reset release is re-timed by one flop so the first real update lands on the second edge.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) run_q <= 1'b0;
    else         run_q <= 1'b1;
  end

  always_comb begin
    int j;
    j         = 0;
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int i = 0; i < N_CH; i++) begin
      j = i_mode ? i : (int'(last_q) + 1 + i) % N_CH;
      if (!arb_found && i_valid[j]) begin
        arb_found = 1'b1;
        arb_idx   = IDX_W'(j);
      end
    end
  end

  assign keep      = (state_q == BURST) && i_valid[owner_q] && (cnt_q < CNT_MAX);
  assign sel       = keep ? owner_q : arb_idx;
  assign sel_valid = keep || arb_found;
  assign advance   = !en_q || i_sdramReady;
  assign xfer      = run_q && advance && sel_valid;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    assign o_ready[k] = xfer && (sel == IDX_W'(k));
    assign o_grant[k] = (state_q == BURST) && (owner_q == IDX_W'(k));
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    addr_d  = addr_q;
    en_d    = en_q;
    if (run_q && advance) begin
      en_d = xfer;
      if (xfer) begin
        data_d  = i_data[int'(sel)*DATA_W +: DATA_W];
        addr_d  = i_addr[int'(sel)*ADDR_W +: ADDR_W];
        state_d = BURST;
        if (keep) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          owner_d = sel;
          last_d  = sel;
          cnt_d   = CNT_W'(1);
        end
      end else begin
        // Nobody to serve at an arbitration point: drop ownership, keep last_q for fairness.
        state_d = IDLE;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= LAST_RST;
      cnt_q   <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      en_q    <= en_d;
    end
  end

  assign o_data        = data_q;
  assign o_addr        = addr_q;
  assign o_enableWrite = en_q;
  assign o_busy        = (state_q == BURST) || en_q;

endmodule

`default_nettype wire

// File: tb/tb_sdram_write_arbiter.sv
// tb_sdram_write_arbiter: directed-vector bench for sdram_write_arbiter (default build plus
// a 4-channel single-beat build).
`default_nettype none

module tb_sdram_write_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        mode;
  logic        sdr_rdy;

  logic [1:0]  a_valid;
  logic [31:0] a_data;
  logic [37:0] a_addr;
  logic [1:0]  a_ready;
  logic [15:0] a_odata;
  logic [18:0] a_oaddr;
  logic        a_en;
  logic [1:0]  a_grant;
  logic        a_busy;

  logic [3:0]  b_valid;
  logic [63:0] b_data;
  logic [75:0] b_addr;
  logic [3:0]  b_ready;
  logic [15:0] b_odata;
  logic [18:0] b_oaddr;
  logic        b_en;
  logic [3:0]  b_grant;
  logic        b_busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sdram_write_arbiter u_dut_a (
    .i_clk         (clk),
    .i_rstn        (rstn),
    .i_mode        (mode),
    .i_valid       (a_valid),
    .i_data        (a_data),
    .i_addr        (a_addr),
    .o_ready       (a_ready),
    .o_data        (a_odata),
    .o_addr        (a_oaddr),
    .o_enableWrite (a_en),
    .i_sdramReady  (sdr_rdy),
    .o_grant       (a_grant),
    .o_busy        (a_busy)
  );

  sdram_write_arbiter #(.N_CH(4), .DATA_W(16), .ADDR_W(19), .MAX_BURST(1)) u_dut_b (
    .i_clk         (clk),
    .i_rstn        (rstn),
    .i_mode        (mode),
    .i_valid       (b_valid),
    .i_data        (b_data),
    .i_addr        (b_addr),
    .o_ready       (b_ready),
    .o_data        (b_odata),
    .o_addr        (b_oaddr),
    .o_enableWrite (b_en),
    .i_sdramReady  (sdr_rdy),
    .o_grant       (b_grant),
    .o_busy        (b_busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ch;
    int ord2 [6];
    ord2 = '{0, 1, 3, 0, 1, 3};

    rstn    = 1'b0;
    mode    = 1'b0;
    sdr_rdy = 1'b1;
    a_valid = 2'b00;
    a_data  = {16'h00C1, 16'h00C0};
    a_addr  = {19'h00200, 19'h00100};
    b_valid = 4'b0000;
    b_data  = {16'h00B3, 16'h00B2, 16'h00B1, 16'h00B0};
    b_addr  = {19'h00033, 19'h00022, 19'h00011, 19'h00000};

    // Reset state
    repeat (3) step();
    a_valid = 2'b11;
    #1;
    chk("rst_en",    a_en,    0);
    chk("rst_data",  a_odata, 0);
    chk("rst_addr",  a_oaddr, 0);
    chk("rst_grant", a_grant, 0);
    chk("rst_busy",  a_busy,  0);
    chk("rst_ready", a_ready, 0);
    chk("rst_b_grant", b_grant, 0);

    // Release: first edge only re-times reset, second edge loads the first beat
    rstn = 1'b1;
    step();
    chk("sync_edge1_en", a_en, 0);
    chk("sync_edge1_ready", a_ready, 2'b01);

    // Round-robin, both valid: 8 beats per owner, no bubbles
    for (int b = 0; b < 32; b++) begin
      step();
      ch = (b / 8) % 2;
      chk($sformatf("rr_en[%0d]", b),    a_en, 1);
      chk($sformatf("rr_data[%0d]", b),  a_odata, ch ? 16'h00C1 : 16'h00C0);
      chk($sformatf("rr_grant[%0d]", b), a_grant, 2'b01 << ch);
      chk($sformatf("rr_ready[%0d]", b), a_ready, 2'b01 << (((b + 1) / 8) % 2));
    end
    chk("rr_addr_last", a_oaddr, 19'h00200);

    // Drain with no requester: strobe drops, data holds, back to idle
    a_valid = 2'b00;
    step();
    chk("idle_en",    a_en,    0);
    chk("idle_hold",  a_odata, 16'h00C1);
    chk("idle_grant", a_grant, 0);
    chk("idle_busy",  a_busy,  0);

    // Stall: pending beat must stay put while SDRAM is not ready
    a_data[15:0] = 16'h1234;
    a_addr[18:0] = 19'h00010;
    a_valid = 2'b01;
    sdr_rdy = 1'b0;
    #1;
    chk("stall_ready_pre", a_ready, 2'b01);
    step();
    chk("stall_load_en",   a_en,    1);
    chk("stall_load_data", a_odata, 16'h1234);
    a_valid = 2'b10;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("stall_en[%0d]", c),    a_en,    1);
      chk($sformatf("stall_data[%0d]", c),  a_odata, 16'h1234);
      chk($sformatf("stall_addr[%0d]", c),  a_oaddr, 19'h00010);
      chk($sformatf("stall_ready[%0d]", c), a_ready, 0);
      chk($sformatf("stall_busy[%0d]", c),  a_busy,  1);
      step();
    end
    sdr_rdy = 1'b1;
    #1;
    chk("stall_release_ready", a_ready, 2'b10);
    step();
    chk("stall_next_data",  a_odata, 16'h00C1);
    chk("stall_next_grant", a_grant, 2'b10);
    a_valid = 2'b00;
    step();
    chk("stall_drain_en", a_en, 0);

    // Fixed priority: ch1 mid-burst is not pre-empted by ch0
    a_data[15:0] = 16'h00C0;
    a_addr[18:0] = 19'h00100;
    mode    = 1'b1;
    a_valid = 2'b10;
    repeat (3) step();
    chk("fp_pre_grant", a_grant, 2'b10);
    a_valid = 2'b11;
    for (int b = 0; b < 21; b++) begin
      step();
      ch = (b < 5) ? 1 : 0;
      chk($sformatf("fp_grant[%0d]", b), a_grant, 2'b01 << ch);
      chk($sformatf("fp_data[%0d]", b),  a_odata, ch ? 16'h00C1 : 16'h00C0);
    end

    // Asynchronous reset mid-burst; first grant afterwards goes to ch0
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_en",    a_en,    0);
    chk("arst_data",  a_odata, 0);
    chk("arst_addr",  a_oaddr, 0);
    chk("arst_grant", a_grant, 0);
    chk("arst_busy",  a_busy,  0);
    chk("arst_ready", a_ready, 0);
    mode = 1'b0;
    step();
    step();
    rstn = 1'b1;
    step();
    chk("arst_edge1_en", a_en, 0);
    step();
    chk("arst_first_en",    a_en,    1);
    chk("arst_first_grant", a_grant, 2'b01);
    chk("arst_first_data",  a_odata, 16'h00C0);

    // Single requester: continuous beats across burst re-grants
    a_valid = 2'b10;
    for (int b = 0; b < 20; b++) begin
      step();
      chk($sformatf("solo_en[%0d]", b),    a_en,    1);
      chk($sformatf("solo_data[%0d]", b),  a_odata, 16'h00C1);
      chk($sformatf("solo_grant[%0d]", b), a_grant, 2'b10);
      chk($sformatf("solo_ready[%0d]", b), a_ready, 2'b10);
    end
    a_valid = 2'b00;

    // 4 channels, single-beat bursts: strict rotation, then skip ch2
    b_valid = 4'b1111;
    for (int b = 0; b < 8; b++) begin
      step();
      ch = b % 4;
      chk($sformatf("rot_grant[%0d]", b), b_grant, 4'b0001 << ch);
      chk($sformatf("rot_data[%0d]", b),  b_odata, 16'h00B0 + 16'(ch));
      chk($sformatf("rot_en[%0d]", b),    b_en,    1);
    end
    b_valid = 4'b1011;
    for (int b = 0; b < 6; b++) begin
      step();
      chk($sformatf("skip_grant[%0d]", b), b_grant, 4'b0001 << ord2[b]);
      chk($sformatf("skip_addr[%0d]", b),  b_oaddr, 19'(ord2[b] * 19'h11));
    end
    b_valid = 4'b0000;
    step();
    chk("rot_drain_busy", b_busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
